seq_feeder: RTL

Front-end controller for the sequential BNN core `seqq`. Accepts input features one B-bit word per beat over a valid/ready stream and assembles them into the packed `N*B` data bus the core expects. Sequences the core's reset/run window for exactly `LAT` cycles, then captures the core's `M`-bit result and presents it on a valid/ready result port. Sits between the feature source and `seqq`. It owns the core's `data` and `rst` inputs.

---
 rtl/seq_pkg.sv | 24 ++
 rtl/seq_cnt.sv | 45 ++++
 rtl/seq_feeder.sv | 124 ++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the seqq front-end: controller states, default geometry
// shared with the core, and index/counter width helpers.
package seq_pkg;

    localparam int N_DEF   = 4;
    localparam int B_DEF   = 4;
    localparam int M_DEF   = 4;
    localparam int LAT_DEF = 5;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_RUN    = 2'd1,
        ST_RESULT = 2'd2
    } state_e;

    // A single-slot vector still needs a 1-bit index.
    function automatic int min1_clog2(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

    localparam int IDX_W = min1_clog2(N_DEF);
    localparam int CNT_W = $clog2(LAT_DEF + 1);

endpackage

// File: rtl/seq_cnt.sv
// Wrapping up-counter with synchronous clear and a terminal-value flag.
module seq_cnt #(
    parameter int W    = 2,
    parameter int LAST = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         last_o
);

    localparam logic [W-1:0] LAST_V = W'(LAST);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            if (cnt_q == LAST_V) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == LAST_V);

endmodule

// File: rtl/seq_feeder.sv
// Front-end for the seqq core: packs feature beats into the core data bus,
// runs the core for LAT edges, then holds its result on a valid/ready port.
module seq_feeder
    import seq_pkg::*;
#(
    parameter int N   = N_DEF,
    parameter int B   = B_DEF,
    parameter int M   = M_DEF,
    parameter int LAT = LAT_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [B-1:0]   in_feat,
    output logic [N*B-1:0] data,
    output logic           core_rst,
    input  logic [M-1:0]   core_out,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [M-1:0]   res
);

    localparam int F_IDX_W = min1_clog2(N);
    localparam int F_CNT_W = $clog2(LAT + 1);

    state_e             state_q, state_d;
    logic [N*B-1:0]     data_q, data_d;
    logic [M-1:0]       res_q, res_d;
    logic [F_IDX_W-1:0] idx_s;
    logic [F_CNT_W-1:0] run_cnt_s;
    logic               idx_last_s;
    logic               run_last_s;
    logic               beat_s;

    assign beat_s = (state_q == ST_LOAD) && in_valid;

    seq_cnt #(.W(F_IDX_W), .LAST(N - 1)) u_idx (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (1'b0),
        .en_i   (beat_s),
        .cnt_o  (idx_s),
        .last_o (idx_last_s)
    );

    // The run counter sits at zero outside RUN, so its terminal flag marks the LAT-th edge.
    seq_cnt #(.W(F_CNT_W), .LAST(LAT - 1)) u_run (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (state_q != ST_RUN),
        .en_i   (state_q == ST_RUN),
        .cnt_o  (run_cnt_s),
        .last_o (run_last_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_LOAD;
            data_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD: begin
                if (beat_s && idx_last_s) state_d = ST_RUN;
                else                      state_d = ST_LOAD;
            end
            ST_RUN: begin
                if (run_last_s) state_d = ST_RESULT;
                else            state_d = ST_RUN;
            end
            ST_RESULT: begin
                if (res_ready) state_d = ST_LOAD;
                else           state_d = ST_RESULT;
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_comb begin
        data_d = data_q;
        res_d  = res_q;
        for (int k = 0; k < N; k++) begin
            if (beat_s && (idx_s == F_IDX_W'(k))) begin
                data_d[k*B +: B] = in_feat;
            end else begin
                data_d[k*B +: B] = data_q[k*B +: B];
            end
        end
        if ((state_q == ST_RUN) && run_last_s) begin
            res_d = core_out;
        end else begin
            res_d = res_q;
        end
    end

    always_comb begin
        in_ready  = 1'b0;
        core_rst  = 1'b1;
        res_valid = 1'b0;
        case (state_q)
            ST_LOAD:   in_ready  = 1'b1;
            ST_RUN:    core_rst  = 1'b0;
            ST_RESULT: res_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                core_rst  = 1'b1;
                res_valid = 1'b0;
            end
        endcase
    end

    assign data = data_q;
    assign res  = res_q;

endmodule
